// File: rtl/eth_pkg.sv
// eth_pkg: FSM states, frame constants and the byte-wide CRC-32 step shared by the GMII transmit MAC
package eth_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_SFD, S_HEAD, S_PAYLOAD, S_PAD, S_FCS, S_IFG, S_DRAIN
  } eth_state_t;
  localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
  localparam logic [7:0]  ETH_SFD       = 8'hD5;
  localparam logic [15:0] ETH_TPID_VLAN = 16'h8100;
  localparam logic [31:0] ETH_CRC_POLY  = 32'h04C11DB7;
  localparam logic [31:0] ETH_CRC_INIT  = 32'hFFFFFFFF;
  // one byte of the reflected CRC-32: data enters LSB first, so the polynomial is bit-reversed
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] p;
    logic [31:0] r;
    for (int i = 0; i < 32; i++) p[i] = ETH_CRC_POLY[31-i];
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ p) : (r >> 1);
    return r;
  endfunction
endpackage

// File: rtl/eth_crc32_d8.sv
// eth_crc32_d8: byte-wide reflected CRC-32 register; clear loads the init value, en folds in one byte
module eth_crc32_d8
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic        clear,
  input  logic [7:0]  data,
  output logic [31:0] crc
);
  logic [31:0] r_crc;
  // clear has priority so a new frame always starts from the init value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_crc <= '0;
    else if (clear) r_crc <= ETH_CRC_INIT;
    else if (en) r_crc <= crc32_byte(r_crc, data);
  end
  assign crc = r_crc;
endmodule

// File: rtl/eth_gmii_tx_mac.sv
// eth_gmii_tx_mac: GMII transmit MAC framing preamble/SFD, header, padded payload, FCS and IFG.
// Define ETH_TX_VLAN_EN to add the vlan_tci port and an 802.1Q tag on every frame.
module eth_gmii_tx_mac
  import eth_pkg::*;
#(
  parameter int PREAMBLE_BYTES = 7,
  parameter int IFG_BYTES      = 12,
  parameter int MIN_FRAME      = 64,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tx_start,
  input  logic [47:0]      dmac,
  input  logic [47:0]      smac,
  input  logic [15:0]      ethertype,
`ifdef ETH_TX_VLAN_EN
  input  logic [15:0]      vlan_tci,
`endif
  input  logic [7:0]       s_tdata,
  input  logic             s_tvalid,
  input  logic             s_tlast,
  output logic             s_tready,
  output logic [7:0]       gmii_txd,
  output logic             gmii_tx_en,
  output logic             gmii_tx_er,
  output logic             tx_busy,
  output logic [CNT_W-1:0] frames_ok,
  output logic [CNT_W-1:0] underruns,
  output logic             underrun_flag,
  input  logic             clr_flag
);
`ifdef ETH_TX_VLAN_EN
  localparam int HL = 18;
`else
  localparam int HL = 14;
`endif
  localparam int HW = HL * 8;
  localparam logic [15:0] PRE_LAST  = 16'(PREAMBLE_BYTES - 2);
  localparam logic [15:0] HEAD_LAST = 16'(HL - 1);
  localparam logic [15:0] IFG_LAST  = 16'(IFG_BYTES - 1);
  localparam logic [15:0] BODY_MIN  = 16'(MIN_FRAME - 4);

  eth_state_t       r_state;
  logic [15:0]      r_cnt;
  logic [15:0]      r_pad_n;
  logic [HW-1:0]    r_hdr;
  logic [7:0]       r_txd;
  logic             r_tx_en;
  logic             r_tx_er;
  logic             r_flag;
  logic [CNT_W-1:0] r_ok;
  logic [CNT_W-1:0] r_urun;
  logic [HW-1:0]    w_hdr;
  logic             w_crc_en;
  logic             w_crc_clr;
  logic [7:0]       w_crc_d;
  logic [31:0]      w_crc;
  logic [31:0]      w_fcs;
  logic [15:0]      w_flen;

`ifdef ETH_TX_VLAN_EN
  assign w_hdr = {dmac, smac, ETH_TPID_VLAN, vlan_tci, ethertype};
`else
  assign w_hdr = {dmac, smac, ethertype};
`endif
  // bytes since DA including the payload byte being taken this cycle
  assign w_flen    = 16'(HL) + r_cnt + 16'd1;
  assign w_fcs     = ~w_crc;
  assign w_crc_clr = (r_state == S_IDLE) && tx_start;
  assign w_crc_en  = (r_state inside {S_HEAD, S_PAD}) || (r_state == S_PAYLOAD && s_tvalid);
  assign w_crc_d   = r_state == S_PAYLOAD ? s_tdata : (r_state == S_PAD ? 8'h00 : r_hdr[HW-1 -: 8]);

  eth_crc32_d8 u_crc (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (w_crc_en),
    .clear  (w_crc_clr),
    .data   (w_crc_d),
    .crc    (w_crc)
  );

  // frame FSM: each cycle's byte is registered on the edge ending it; the accepting IDLE cycle issues preamble byte one
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pad_n <= '0;
      r_hdr   <= '0;
      r_txd   <= '0;
      r_tx_en <= 1'b0;
      r_tx_er <= 1'b0;
      r_flag  <= 1'b0;
      r_ok    <= '0;
      r_urun  <= '0;
    end else begin
      r_txd   <= 8'h00;
      r_tx_en <= 1'b0;
      r_tx_er <= 1'b0;
      r_cnt   <= r_cnt + 16'd1;
      if (clr_flag) r_flag <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (tx_start) begin
            r_state <= PREAMBLE_BYTES == 1 ? S_SFD : S_PRE;
            r_hdr   <= w_hdr;
            r_txd   <= ETH_PREAMBLE;
            r_tx_en <= 1'b1;
          end
        end
        S_PRE: begin
          r_txd   <= ETH_PREAMBLE;
          r_tx_en <= 1'b1;
          if (r_cnt == PRE_LAST) begin
            r_state <= S_SFD;
            r_cnt   <= '0;
          end
        end
        S_SFD: begin
          r_txd   <= ETH_SFD;
          r_tx_en <= 1'b1;
          r_state <= S_HEAD;
          r_cnt   <= '0;
        end
        S_HEAD: begin
          r_txd   <= r_hdr[HW-1 -: 8];
          r_tx_en <= 1'b1;
          r_hdr   <= r_hdr << 8;
          if (r_cnt == HEAD_LAST) begin
            r_state <= S_PAYLOAD;
            r_cnt   <= '0;
          end
        end
        S_PAYLOAD: begin
          r_txd   <= s_tvalid ? s_tdata : 8'h00;
          r_tx_en <= 1'b1;
          r_tx_er <= !s_tvalid;
          if (!s_tvalid) begin
            r_state <= S_DRAIN;
            r_cnt   <= '0;
            r_urun  <= r_urun + CNT_W'(1);
            r_flag  <= 1'b1;
          end else if (s_tlast) begin
            r_state <= w_flen < BODY_MIN ? S_PAD : S_FCS;
            r_pad_n <= BODY_MIN - w_flen;
            r_cnt   <= '0;
          end
        end
        S_PAD: begin
          r_tx_en <= 1'b1;
          if (r_cnt == r_pad_n - 16'd1) begin
            r_state <= S_FCS;
            r_cnt   <= '0;
          end
        end
        S_FCS: begin
          r_txd   <= w_fcs[{r_cnt[1:0], 3'b000} +: 8];
          r_tx_en <= 1'b1;
          if (r_cnt == 16'd3) begin
            r_state <= S_IFG;
            r_cnt   <= '0;
            r_ok    <= r_ok + CNT_W'(1);
          end
        end
        S_IFG: begin
          if (r_cnt == IFG_LAST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end
        end
        S_DRAIN: begin
          if (s_tvalid && s_tlast) begin
            r_state <= S_IFG;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign s_tready      = (r_state == S_PAYLOAD) || (r_state == S_DRAIN);
  assign tx_busy       = r_state != S_IDLE;
  assign gmii_txd      = r_txd;
  assign gmii_tx_en    = r_tx_en;
  assign gmii_tx_er    = r_tx_er;
  assign frames_ok     = r_ok;
  assign underruns     = r_urun;
  assign underrun_flag = r_flag;
endmodule

// File: doc/eth_gmii_tx_mac.md
ETH_GMII_TX_MAC -- requirements
Module: eth_gmii_tx_mac

Interface
REQ-001 Parameter PREAMBLE_BYTES, default 7: number of 0x55 bytes sent before the SFD; legal range 1..15.
REQ-002 Parameter IFG_BYTES, default 12: idle cycles after the FCS; legal range 1..255.
REQ-003 Parameter MIN_FRAME, default 64: minimum frame length in bytes, DA through FCS inclusive.
REQ-004 Parameter CNT_W, default 16: width of the statistics counters.
REQ-005 clk  in  1  GMII transmit clock, the single clock; all logic is on its rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 tx_start  in  1  frame request; sampled only in IDLE.
REQ-008 dmac, smac  in  48 each  destination and source MAC, latched on an accepted tx_start.
REQ-009 ethertype  in  16  EtherType, latched on an accepted tx_start.
REQ-010 vlan_tci  in  16  802.1Q TCI; present only with ETH_TX_VLAN_EN.
REQ-011 s_tdata  in  8  payload byte.
REQ-012 s_tvalid  in  1  payload byte valid.
REQ-013 s_tlast  in  1  last payload byte of the frame.
REQ-014 s_tready  out  1  payload byte accepted (s_tvalid & s_tready).
REQ-015 gmii_txd  out  8  GMII transmit data, registered.
REQ-016 gmii_tx_en  out  1  GMII transmit enable, registered.
REQ-017 gmii_tx_er  out  1  GMII transmit error, registered.
REQ-018 tx_busy  out  1  high in every state except IDLE.
REQ-019 frames_ok  out  CNT_W  count of frames completed with FCS; wraps modulo 2^CNT_W.
REQ-020 underruns  out  CNT_W  count of aborted frames; wraps.
REQ-021 underrun_flag  out  1  sticky underrun indicator; cleared by the clr_flag input (in, 1).

Function
REQ-022 States: IDLE, PRE, SFD, HEAD, PAYLOAD, PAD, FCS, IFG, DRAIN.
- One 16-bit byte counter, reset to 0 on every state change.
REQ-023 IDLE -> PRE when tx_start=1; header latched that cycle; first 0x55 appears on gmii_txd with gmii_tx_en=1 on the next rising edge.
REQ-024 PRE emits PREAMBLE_BYTES x 0x55, then SFD emits one 0xD5.
REQ-025 HEAD emits DA then SA (MSB byte first), then, with VLAN, 0x81, 0x00, TCI[15:8], TCI[7:0], then ethertype MSB byte first.
REQ-026 PAYLOAD: s_tready=1 (decoded from registered state); each handshake drives s_tdata onto gmii_txd on the next edge.
REQ-027 On a handshake with s_tlast=1: next state is PAD if the bytes sent since DA < MIN_FRAME-4, else FCS.
REQ-028 PAD emits 0x00 until DA..pad totals MIN_FRAME-4 bytes; with the defaults this means payload is padded to 46 bytes without VLAN and 42 with VLAN.
REQ-029 CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) covers DA through the last pad byte; preamble and SFD are excluded.
REQ-030 FCS emits the complemented CRC over 4 bytes, least significant byte first; then IFG holds gmii_tx_en=0 for IFG_BYTES cycles, then IDLE.
- frames_ok increments on the FCS -> IFG transition.
REQ-031 Underrun: s_tvalid=0 in PAYLOAD -> that cycle's output is gmii_tx_en=1, gmii_tx_er=1, gmii_txd=0x00.
- underruns increments and underrun_flag sets.
- Next state is DRAIN, or IFG if the last byte has already been taken.
REQ-032 DRAIN: s_tready=1, gmii_tx_en=0; bytes are discarded until a handshake with s_tlast=1, then IFG.
REQ-033 tx_start outside IDLE is ignored; there is no queuing.
REQ-034 Simultaneous underrun and clr_flag: set wins.
REQ-035 Outside PRE..FCS, gmii_tx_en=0, gmii_tx_er=0, gmii_txd=0x00.

Reset
REQ-036 reset_n=0 asynchronously forces IDLE and clears to 0 all outputs, both counters, underrun_flag, the latched header and the CRC register.
- A frame in flight is truncated; no FCS and no tx_er are sent.
REQ-037 After deassertion the block is idle; the first tx_start is accepted on any edge.

Configuration
REQ-038 Macro ETH_TX_VLAN_EN.
- Defined: vlan_tci port exists and every frame carries the 4-byte 802.1Q tag.
- Undefined: vlan_tci is absent and HEAD is 14 bytes.
- MIN_FRAME semantics are identical in both builds.

Structure
REQ-039 Package eth_pkg holds the state enum, ETH_PREAMBLE=8'h55, ETH_SFD=8'hD5, ETH_TPID_VLAN=16'h8100 and the CRC polynomial/init constants.
REQ-040 Sub-module eth_crc32_d8: byte-wide reflected CRC-32 with en, clear and crc outputs; one instance.

Verification
REQ-041 60-byte payload, no VLAN -> 7x55, D5, 14 header bytes, 60 data bytes, 4 FCS bytes.
- Running the CRC register over DA..FCS leaves residue 0xDEBB20E3.
- Then 12 idle cycles; frames_ok=1.
REQ-042 1-byte payload -> 45 bytes of 0x00 pad; DA..FCS totals 64 bytes.
- With ETH_TX_VLAN_EN: 41 pad bytes, 81 00 TCI after SA, and the total is still 64.
REQ-043 s_tvalid dropped after 10 of 100 bytes -> 11th output cycle has tx_er=1.
- 90 remaining bytes are drained with tx_en=0; underruns=1 and underrun_flag=1.
- clr_flag clears the flag; next frame completes normally.
REQ-044 reset_n pulsed low mid-HEAD -> gmii_tx_en=0 before the next edge and all counters read 0.
- A following tx_start sends a complete frame.
REQ-045 tx_start held high through a frame -> next frame's preamble begins exactly IFG_BYTES idle cycles after the last FCS byte.
- Test with IFG_BYTES=12 and with IFG_BYTES=1.
REQ-046 CNT_W=4, 16 good frames -> frames_ok wraps to 0.
